// File: rtl/crc_lut_arb.sv
`default_nettype none
// ============================================================================
//  Module      : crc_lut_arb
//  Description : Round-robin arbiter and two-stage pipeline sharing a single
//                256x32 CRC lookup table between NUM_REQ requesters. Each
//                requester presents an 8-bit index over valid/ready and gets
//                the table word back on a backpressured response channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc_lut_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*8-1:0] req_addr,
    output logic [31:0]          lut_addr,
    input  logic [31:0]          lut_rdata,
    output logic [NUM_REQ-1:0]   rsp_valid,
    input  logic [NUM_REQ-1:0]   rsp_ready,
    output logic [31:0]          rsp_data,
    output logic [CNT_W-1:0]     txn_count
);

    localparam int c_IDX_W = 8;
    localparam int c_PAD_W = 32 - c_IDX_W;

    // Stage S1: accepted request, drives the table address
    logic               r_s1_valid;
    logic [ID_W-1:0]    r_s1_id;
    logic [c_IDX_W-1:0] r_s1_addr;

    // Stage S2: captured table word, drives the response channel
    logic               r_s2_valid;
    logic [ID_W-1:0]    r_s2_id;
    logic [31:0]        r_s2_data;

    // Arbitration state and statistics
    logic [ID_W-1:0]    r_rr_ptr;
    logic [CNT_W-1:0]   r_txn_count;

    // Combinational control
    logic               w_s2_adv;
    logic               w_s1_adv;
    logic               w_grant_found;
    logic [ID_W-1:0]    w_grant_id;
    logic               w_accept;
    logic [c_IDX_W-1:0] w_sel_addr;
    logic [ID_W-1:0]    w_rr_next;

    // S2 empties when it is empty or its owner takes the response; S1 can
    // move whenever S2 can, so a drain and a new acceptance share one cycle.
    assign w_s2_adv = !r_s2_valid || rsp_ready[r_s2_id];
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign w_accept = w_s1_adv && w_grant_found;

    // Round-robin search: first asserted valid at or after rr_ptr, wrapping.
    // Scanning from the far end and overwriting leaves the nearest hit.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_id    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                w_grant_found = 1'b1;
                w_grant_id    = ID_W'(idx);
            end
        end
    end

    // One-hot ready to the winner, only when S1 is able to take it
    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_grant_id] = 1'b1;
        end
    end

    // Pick the winner's table index out of the packed address bus
    always_comb begin
        w_sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_id == ID_W'(i)) begin
                w_sel_addr = req_addr[c_IDX_W*i +: c_IDX_W];
            end
        end
    end

    // Pointer moves just past the winner; explicit wrap so non-power-of-two
    // requester counts never produce an out-of-range id.
    assign w_rr_next = (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0
                                                           : w_grant_id + ID_W'(1);

    // S1 register: load on acceptance, empty when it advances without one
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_valid <= 1'b0;
            r_s1_id    <= '0;
            r_s1_addr  <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_id   <= w_grant_id;
                r_s1_addr <= w_sel_addr;
            end
        end
    end

    // S2 register: table data is sampled only on the edge S2 advances
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s2_valid <= 1'b0;
            r_s2_id    <= '0;
            r_s2_data  <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_id    <= r_s1_id;
            r_s2_data  <= lut_rdata;
        end
    end

    // Round-robin pointer and transaction counter move only on a handshake
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr_ptr    <= '0;
            r_txn_count <= '0;
        end else if (w_accept) begin
            r_rr_ptr    <= w_rr_next;
            r_txn_count <= r_txn_count + CNT_W'(1);
        end
    end

    assign lut_addr  = {{c_PAD_W{1'b0}}, r_s1_addr};
    assign rsp_data  = r_s2_data;
    assign txn_count = r_txn_count;

    // Response valid is decoded per requester from the S2 owner id
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp_valid
            assign rsp_valid[gi] = r_s2_valid && (r_s2_id == ID_W'(gi));
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_crc_lut_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crc_lut_arb
//  Description : Directed self-checking bench for crc_lut_arb with a small
//                behavioural table model on the lut_addr/lut_rdata pair.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_lut_arb;

    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 16;

    logic                 clk;
    logic                 rstn;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*8-1:0] req_addr;
    logic [31:0]          lut_addr;
    logic [31:0]          lut_rdata;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [NUM_REQ-1:0]   rsp_ready;
    logic [31:0]          rsp_data;
    logic [CNT_W-1:0]     txn_count;

    int n_tests;
    int n_fail;

    crc_lut_arb #(
        .NUM_REQ (NUM_REQ),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .lut_addr  (lut_addr),
        .lut_rdata (lut_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .txn_count (txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table model: the entries exercised by the bench, plus a filler pattern
    function automatic logic [31:0] lut_fn(input logic [7:0] a);
        case (a)
            8'h00:   lut_fn = 32'h00000000;
            8'h01:   lut_fn = 32'h4f576811;
            8'hFF:   lut_fn = 32'h0c526c49;
            8'h10:   lut_fn = 32'he672f7cc;
            default: lut_fn = {4{a}} ^ 32'hA5A5A5A5;
        endcase
    endfunction

    always_comb lut_rdata = lut_fn(lut_addr[7:0]);

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        cyc();
        cyc();
        rstn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 4'hF;
        req_addr  = {8'h10, 8'hFF, 8'h01, 8'h00};
        cyc();
        cyc();
        n_tests++;
        if (rsp_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_rsp_valid: got %b expected %b", rsp_valid, 4'b0000);
        end
        n_tests++;
        if (rsp_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rsp_data: got %h expected %h", rsp_data, 32'h0);
        end
        n_tests++;
        if (lut_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_lut_addr: got %h expected %h", lut_addr, 32'h0);
        end
        n_tests++;
        if (txn_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_txn_count: got %h expected %h", txn_count, 16'h0);
        end
        rstn = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %b expected %b", req_ready, 4'b0001);
        end
        cyc();
        req_valid = '0;
        n_tests++;
        if (txn_count !== 16'd1) begin
            n_fail++;
            $display("FAIL reset_first_txn: got %0d expected %0d", txn_count, 1);
        end
        cyc();
        n_tests++;
        if (rsp_valid !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_rsp: got %b expected %b", rsp_valid, 4'b0001);
        end
        cyc();
    endtask

    task automatic test_single();
        do_reset();
        req_addr  = {8'h10, 8'hFF, 8'h01, 8'h01};
        req_valid = 4'b0001;
        rsp_ready = 4'hF;
        #1;
        n_tests++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_ready: got %b expected %b", req_ready, 4'b0001);
        end
        cyc();
        req_valid = '0;
        n_tests++;
        if (lut_addr !== 32'h00000001) begin
            n_fail++;
            $display("FAIL single_lut_addr: got %h expected %h", lut_addr, 32'h1);
        end
        n_tests++;
        if (txn_count !== 16'd1) begin
            n_fail++;
            $display("FAIL single_txn: got %0d expected %0d", txn_count, 1);
        end
        n_tests++;
        if (rsp_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_early_rsp: got %b expected %b", rsp_valid, 4'b0000);
        end
        cyc();
        n_tests++;
        if (rsp_valid !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_rsp_valid: got %b expected %b", rsp_valid, 4'b0001);
        end
        n_tests++;
        if (rsp_data !== 32'h4f576811) begin
            n_fail++;
            $display("FAIL single_rsp_data: got %h expected %h", rsp_data, 32'h4f576811);
        end
        cyc();
        n_tests++;
        if (rsp_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_rsp_once: got %b expected %b", rsp_valid, 4'b0000);
        end
    endtask

    task automatic test_contention();
        logic [31:0] exp_data [4];
        exp_data[0] = 32'h00000000;
        exp_data[1] = 32'h4f576811;
        exp_data[2] = 32'h0c526c49;
        exp_data[3] = 32'he672f7cc;
        do_reset();
        req_addr  = {8'h10, 8'hFF, 8'h01, 8'h00};
        req_valid = 4'hF;
        rsp_ready = 4'hF;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_tests++;
            if (req_ready !== (4'b0001 << (i % 4))) begin
                n_fail++;
                $display("FAIL contention_grant[%0d]: got %b expected %b",
                         i, req_ready, 4'b0001 << (i % 4));
            end
            cyc();
            if (i > 0) begin
                n_tests++;
                if (rsp_valid !== (4'b0001 << ((i - 1) % 4)) ||
                    rsp_data !== exp_data[(i - 1) % 4]) begin
                    n_fail++;
                    $display("FAIL contention_rsp[%0d]: got %b/%h expected %b/%h", i - 1,
                             rsp_valid, rsp_data, 4'b0001 << ((i - 1) % 4),
                             exp_data[(i - 1) % 4]);
                end
            end
        end
        req_valid = '0;
        cyc();
        n_tests++;
        if (rsp_valid !== 4'b1000 || rsp_data !== 32'he672f7cc) begin
            n_fail++;
            $display("FAIL contention_last_rsp: got %b/%h expected %b/%h",
                     rsp_valid, rsp_data, 4'b1000, 32'he672f7cc);
        end
        n_tests++;
        if (txn_count !== 16'd8) begin
            n_fail++;
            $display("FAIL contention_txn: got %0d expected %0d", txn_count, 8);
        end
        cyc();
        n_tests++;
        if (rsp_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL contention_drain: got %b expected %b", rsp_valid, 4'b0000);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_addr  = {8'h10, 8'hFF, 8'h01, 8'h00};
        req_valid = 4'b0010;
        rsp_ready = 4'hF;
        cyc();
        req_valid = 4'b0100;
        rsp_ready = 4'b1101;
        #1;
        n_tests++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL bp_fill_ready: got %b expected %b", req_ready, 4'b0100);
        end
        cyc();
        req_valid = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (rsp_valid !== 4'b0010 || rsp_data !== 32'h4f576811) begin
                n_fail++;
                $display("FAIL bp_hold_rsp[%0d]: got %b/%h expected %b/%h", i,
                         rsp_valid, rsp_data, 4'b0010, 32'h4f576811);
            end
            n_tests++;
            if (req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_hold_ready[%0d]: got %b expected %b", i, req_ready, 4'b0000);
            end
            n_tests++;
            if (lut_addr !== 32'h000000FF) begin
                n_fail++;
                $display("FAIL bp_hold_s1[%0d]: got %h expected %h", i, lut_addr, 32'hFF);
            end
            cyc();
        end
        req_valid = '0;
        rsp_ready = 4'hF;
        cyc();
        n_tests++;
        if (rsp_valid !== 4'b0100 || rsp_data !== 32'h0c526c49) begin
            n_fail++;
            $display("FAIL bp_release_rsp2: got %b/%h expected %b/%h",
                     rsp_valid, rsp_data, 4'b0100, 32'h0c526c49);
        end
        cyc();
        n_tests++;
        if (rsp_valid !== 4'b0000 || txn_count !== 16'd2) begin
            n_fail++;
            $display("FAIL bp_release_end: got %b/%0d expected %b/%0d",
                     rsp_valid, txn_count, 4'b0000, 2);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        req_addr  = {8'h10, 8'hFF, 8'h01, 8'h00};
        req_valid = 4'b0001;
        rsp_ready = 4'hF;
        cyc();
        req_valid = 4'b0101;
        #1;
        n_tests++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL fair_first: got %b expected %b", req_ready, 4'b0100);
        end
        cyc();
        n_tests++;
        if (rsp_valid !== 4'b0001 || rsp_data !== 32'h00000000) begin
            n_fail++;
            $display("FAIL fair_rsp0: got %b/%h expected %b/%h",
                     rsp_valid, rsp_data, 4'b0001, 32'h0);
        end
        n_tests++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL fair_second: got %b expected %b", req_ready, 4'b0001);
        end
        cyc();
        req_valid = '0;
        n_tests++;
        if (rsp_valid !== 4'b0100 || rsp_data !== 32'h0c526c49) begin
            n_fail++;
            $display("FAIL fair_rsp2: got %b/%h expected %b/%h",
                     rsp_valid, rsp_data, 4'b0100, 32'h0c526c49);
        end
        cyc();
        n_tests++;
        if (rsp_valid !== 4'b0001 || rsp_data !== 32'h00000000) begin
            n_fail++;
            $display("FAIL fair_rsp0_again: got %b/%h expected %b/%h",
                     rsp_valid, rsp_data, 4'b0001, 32'h0);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_addr  = {8'h10, 8'hFF, 8'h01, 8'h00};
        req_valid = 4'b0010;
        rsp_ready = 4'b0000;
        cyc();
        cyc();
        n_tests++;
        if (rsp_valid !== 4'b0010 || txn_count !== 16'd2) begin
            n_fail++;
            $display("FAIL mid_fill: got %b/%0d expected %b/%0d",
                     rsp_valid, txn_count, 4'b0010, 2);
        end
        req_valid = 4'b1010;
        #2;
        rstn = 1'b0;
        #1;
        n_tests++;
        if (rsp_valid !== 4'b0000 || txn_count !== 16'd0 || lut_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_clear: got %b/%0d/%h expected %b/%0d/%h",
                     rsp_valid, txn_count, lut_addr, 4'b0000, 0, 32'h0);
        end
        n_tests++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL mid_ptr_clear: got %b expected %b", req_ready, 4'b0010);
        end
        req_valid = '0;
        rsp_ready = 4'hF;
        cyc();
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_tests++;
            if (rsp_valid !== 4'b0000) begin
                n_fail++;
                $display("FAIL mid_stale[%0d]: got %b expected %b", i, rsp_valid, 4'b0000);
            end
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rstn      = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        rsp_ready = '1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_fairness();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
